multi_channel_accumulator: RTL

MULTI_CHANNEL_ACCUMULATOR -- requirements
Module: multi_channel_accumulator

---
 rtl/multi_channel_accumulator_pkg.sv | 24 ++
 rtl/multi_channel_accumulator_acc_sat_add.sv | 35 +++
 rtl/multi_channel_accumulator.sv | 100 ++++++++++
 3 files changed

// File: rtl/multi_channel_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// multi_channel_accumulator_pkg
//
// Shared constants and helpers for the multi-channel accumulator:
//   DEFAULT_WIDTH     default data / accumulator width in bits
//   DEFAULT_CHANNELS  default number of independent accumulators
//   MODE_WRAP         SATURATE value selecting wrap-around on overflow
//   MODE_SATURATE     SATURATE value selecting clamp-to-max on overflow
//   chan_w()          width of a channel index for a given channel count
// ---------------------------------------------------------------------------
package multi_channel_accumulator_pkg;

    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_CHANNELS = 4;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SATURATE = 1;

    // Index width for n channels; never below 1 so a port is always legal.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : multi_channel_accumulator_pkg

// File: rtl/multi_channel_accumulator_acc_sat_add.sv
// ---------------------------------------------------------------------------
// acc_sat_add
//
// Combinational unsigned adder with overflow detection and optional clamp.
//   a, b      : WIDTH-bit unsigned operands
//   saturate  : 0 = keep low WIDTH bits on overflow, 1 = clamp to all-ones
//   sum       : WIDTH-bit result after wrap or clamp
//   ovf       : carry out of the top bit (overflow event)
// ---------------------------------------------------------------------------
module acc_sat_add #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             saturate,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    // One extra bit so the carry out of bit WIDTH-1 is visible.
    logic [WIDTH:0] full_sum;

    // NOTE: every signal written in always_comb gets a value on every path
    // (here by unconditional assignment), otherwise a latch is inferred.
    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b};
        ovf      = full_sum[WIDTH];
        if (ovf && saturate) begin
            sum = '1;
        end else begin
            sum = full_sum[WIDTH-1:0];
        end
    end

endmodule : acc_sat_add

// File: rtl/multi_channel_accumulator.sv
// ---------------------------------------------------------------------------
// multi_channel_accumulator
//
// CHANNELS independent WIDTH-bit unsigned accumulators sharing one adder.
// One operation (add, clear, or clear+load) is accepted per clock.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        synchronous active-high reset
//   in_valid     request an add of `in` to channel in_channel
//   in_channel   target channel for add / clear
//   in           unsigned addend
//   clear        zero accumulator and overflow flag of in_channel
//                (with in_valid: load `in` instead of adding)
//   out_valid    one-cycle pulse per accepted add or clear
//   out_channel  channel the registered `out` refers to
//   out          new stored value of out_channel, one cycle after the edge
//   overflow     per-channel sticky overflow flags
//   rd_channel   combinational read select
//   rd_data      registered accumulator value of rd_channel, no latency
// ---------------------------------------------------------------------------
module multi_channel_accumulator
    import multi_channel_accumulator_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [chan_w(CHANNELS)-1:0]   in_channel,
    input  logic [WIDTH-1:0]              in,
    input  logic                          clear,
    output logic                          out_valid,
    output logic [chan_w(CHANNELS)-1:0]   out_channel,
    output logic [WIDTH-1:0]              out,
    output logic [CHANNELS-1:0]           overflow,
    input  logic [chan_w(CHANNELS)-1:0]   rd_channel,
    output logic [WIDTH-1:0]              rd_data
);

    logic [WIDTH-1:0] acc [CHANNELS];

    logic             op_accept;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;

    // A clear replaces the current value with zero, so clear+add becomes a
    // load of `in` and clear alone produces zero. With a zero operand the
    // adder can never overflow, which keeps the flag cleared on a load.
    always_comb begin
        op_accept = in_valid | clear;
        add_a     = clear    ? '0 : acc[in_channel];
        add_b     = in_valid ? in : '0;
    end

    acc_sat_add #(
        .WIDTH (WIDTH)
    ) u_acc_sat_add (
        .a        (add_a),
        .b        (add_b),
        .saturate (SATURATE != MODE_WRAP),
        .sum      (add_sum),
        .ovf      (add_ovf)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the accumulator array is plain flops, not a RAM macro,
            // so clearing every entry on reset is legal and required here.
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            overflow    <= '0;
            out_valid   <= 1'b0;
            out_channel <= '0;
            out         <= '0;
        end else begin
            out_valid <= op_accept;
            if (op_accept) begin
                acc[in_channel] <= add_sum;
                // Clear restarts the sticky flag; otherwise it only accumulates.
                overflow[in_channel] <= clear ? add_ovf
                                              : (overflow[in_channel] | add_ovf);
                out_channel <= in_channel;
                out         <= add_sum;
            end
        end
    end

    // Reads see registered state, so a channel written this cycle still
    // returns its pre-edge value.
    assign rd_data = acc[rd_channel];

endmodule : multi_channel_accumulator
